irq_pend_ctrl: RTL and testbench
================================

// Module: irq_pend_ctrl
// PURPOSE
//  Upstream feeder and downstream consumer for the 8:3 priority encoder.
//  - Captures 8 interrupt lines into sticky pending bits and applies a mask.
//  - Drives the encoder's i/en inputs and samples its 3-bit code.
//  - Issues one vector at a time to the CPU with a req/ack handshake.
//  - Clears the serviced pending bit on acknowledge.
// PARAMETERS
//  EDGE_MODE    1  1: set pending on rising edge of irq_in; 0: set while irq_in high (level)
//  ACK_TIMEOUT  0  cycles in REQ before the request is withdrawn and re-arbitrated; 0 disables
// PORTS
//  clk            in   1  single clock, rising edge
//  rst_n          in   1  asynchronous, active-low reset
//  irq_in         in   8  raw interrupt lines
//  irq_mask       in   8  1 = line masked (stays pending, never arbitrated)
//  enc_i_o        out  8  pend & ~irq_mask, to encoder i
//  enc_en_o       out  1  encoder enable; high only in ARB
//  enc_code_i     in   3  encoder y; valid only while enc_en_o=1 (z otherwise)
//  irq_req_o      out  1  vector request to CPU
//  irq_vec_o      out  3  vector; stable while irq_req_o=1
//  irq_ack_i      in   1  CPU acknowledge of the current vector
//  pend_o         out  8  raw pending register (status)
// BEHAVIOUR
//  Reset: pend=0, state=IDLE, enc_en_o=0, irq_req_o=0, irq_vec_o=0, timeout counter=0, edge history=0.
//  Pending set:
//  - EDGE_MODE=1: pend[k] set the cycle after irq_in[k] goes 0->1.
//  - EDGE_MODE=0: pend[k] set every cycle irq_in[k]=1.
//  Pending clear: only by ack of vector k, or reset.
//  - Same-cycle set and ack-clear of one bit: set wins.
//  FSM (state register in irq_pkg):
//  - IDLE: if |enc_i_o -> ARB, else stay.
//  - ARB: enc_en_o=1; register enc_code_i into irq_vec_o -> REQ.
//  - REQ: irq_req_o=1.
//    - irq_ack_i=1 -> clear pend[irq_vec_o]; go to IDLE; irq_req_o low next cycle.
//    - ACK_TIMEOUT>0 and counter reaches ACK_TIMEOUT-1 without ack -> IDLE, pend unchanged.
//  - irq_ack_i outside REQ is ignored.
//  Encoder code 000 is ambiguous (line 0 or none). The block only enters ARB when |enc_i_o=1, so 000 there always means line 0.
//  Mask changes while in REQ do not withdraw the issued vector. A masked line becomes eligible in the next IDLE.
//  Latency, EDGE_MODE=1, no sync: edge on cycle n -> pend cycle n+1 -> ARB n+2 -> irq_req_o n+3.
//  Back-to-back: after ack, IDLE for 1 cycle before the next ARB (min 3-cycle request spacing).
//  Reset asserted mid-handshake: all outputs drop asynchronously and the pending vector is lost.
// CONFIGURATION
//  IRQ_SYNC_EN defined:
//  - irq_in passes through a 2-flop synchronizer (reset to 0) before edge/level detect.
//  - Adds 2 cycles of latency; irq_req_o on n+5.
//  IRQ_SYNC_EN undefined: irq_in is used directly; the source must be synchronous to clk.
// STRUCTURE
//  irq_pkg: N_IRQ=8, CODE_W=3, state enum {IDLE, ARB, REQ}, timeout counter width function.
//  Sub-module irq_edge_det:
//  - Holds the per-line synchronizer (under IRQ_SYNC_EN) and the history flop.
//  - Produces set pulses per EDGE_MODE.
//  The encoder stays external, connected by enc_i_o/enc_en_o/enc_code_i.
// TESTING
//  1 Edge, no sync: irq_in=0x20 from cycle 0 -> pend_o=0x20 @1, irq_req_o=1 with irq_vec_o=5 @3; ack @5 -> pend_o=0x00 @6.
//  2 Priority: irq_in=0x0A together -> vec 3 first; after ack, vec 1; pend_o 0x0A->0x02->0x00.
//  3 Line 0: irq_in=0x01 -> irq_req_o with vec 0; irq_in=0x00 -> irq_req_o never asserts.
//  4 Mask: irq_mask=0x80, irq_in=0x81 -> vec 0 only, pend_o stays 0x80.
//    Clear mask -> vec 7 issued.
//  5 Timeout (ACK_TIMEOUT=4), no ack -> irq_req_o drops after 4 cycles, re-asserts with same vec; set+ack same bit same cycle -> bit stays 1.
//  6 Reset: assert rst_n=0 while irq_req_o=1 -> irq_req_o, pend_o, irq_vec_o = 0 immediately.
//    Repeat test 1 with IRQ_SYNC_EN -> irq_req_o @5.

Source files
------------

// File: rtl/irq_pend_ctrl_pkg.sv
// Shared constants, FSM state type and counter sizing helper for the
// interrupt pending controller.
package irq_pkg;

    localparam int N_IRQ  = 8;
    localparam int CODE_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        REQ  = 2'd2
    } state_e;

    // Width of a counter that must hold 0..t-1; never narrower than one bit.
    function automatic int cnt_width(input int unsigned t);
        cnt_width = (t < 2) ? 1 : $clog2(t);
    endfunction

endpackage

// File: rtl/irq_pend_ctrl_if.sv
// Encoder link and CPU vector handshake of the interrupt pending controller.
// master = controller side, slave = encoder/CPU side.
interface irq_pend_ctrl_if;
    import irq_pkg::*;

    logic [N_IRQ-1:0]  enc_i_o;
    logic              enc_en_o;
    logic [CODE_W-1:0] enc_code_i;
    logic              irq_req_o;
    logic [CODE_W-1:0] irq_vec_o;
    logic              irq_ack_i;

    modport master (
        output enc_i_o, enc_en_o, irq_req_o, irq_vec_o,
        input  enc_code_i, irq_ack_i
    );

    modport slave (
        input  enc_i_o, enc_en_o, irq_req_o, irq_vec_o,
        output enc_code_i, irq_ack_i
    );

endinterface

// File: rtl/irq_pend_ctrl_edge_det.sv
// Per-line set-pulse generator: optional 2-flop synchronizer (IRQ_SYNC_EN)
// followed by rising-edge (EDGE_MODE=1) or level (EDGE_MODE=0) detection.
module irq_edge_det
    import irq_pkg::*;
#(
    parameter int EDGE_MODE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_i,
    output logic [N_IRQ-1:0] set_o
);

    logic [N_IRQ-1:0] line;

`ifdef IRQ_SYNC_EN
    logic [N_IRQ-1:0] sync1_q;
    logic [N_IRQ-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
        end
    end

    assign line = sync2_q;
`else
    assign line = irq_i;
`endif

    if (EDGE_MODE != 0) begin : g_edge
        logic [N_IRQ-1:0] hist_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) hist_q <= '0;
            else        hist_q <= line;
        end

        assign set_o = line & ~hist_q;
    end else begin : g_level
        assign set_o = line;
    end

endmodule

// File: rtl/irq_pend_ctrl.sv
// Sticky pending register, mask, external 8:3 encoder hand-off and one-at-a-time
// req/ack vector issue to the CPU. Build option: IRQ_SYNC_EN (input synchronizer).
module irq_pend_ctrl
    import irq_pkg::*;
#(
    parameter int          EDGE_MODE   = 1,
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] irq_mask,
    output logic [N_IRQ-1:0] pend_o,
    irq_pend_ctrl_if.master  bus
);

    localparam int CNT_W = cnt_width(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST =
        (ACK_TIMEOUT == 0) ? '0 : CNT_W'(ACK_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [N_IRQ-1:0]  pend_q,  pend_d;
    logic [CODE_W-1:0] vec_q,   vec_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [N_IRQ-1:0]  set;
    logic [N_IRQ-1:0]  clr;
    logic              timeout_hit;

    irq_edge_det #(.EDGE_MODE(EDGE_MODE)) u_edge_det (
        .clk   (clk),
        .rst_n (rst_n),
        .irq_i (irq_in),
        .set_o (set)
    );

    assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = '0;
        clr     = '0;
        case (state_q)
            IDLE: if (|bus.enc_i_o) state_d = ARB;
            // Entry to ARB implies a non-empty request set, so code 0 is line 0.
            ARB: begin
                vec_d   = bus.enc_code_i;
                state_d = REQ;
            end
            REQ: begin
                if (bus.irq_ack_i) begin
                    clr     = N_IRQ'(1) << vec_q;
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new set arriving with the ack of the same line keeps it pending.
        pend_d = (pend_q & ~clr) | set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.enc_i_o   = pend_q & ~irq_mask;
    assign bus.enc_en_o  = (state_q == ARB);
    assign bus.irq_req_o = (state_q == REQ);
    assign bus.irq_vec_o = vec_q;
    assign pend_o        = pend_q;

endmodule

// File: tb/tb_irq_pend_ctrl.sv
// Scoreboard bench for irq_pend_ctrl: directed stimulus queues expected vectors,
// a monitor pops and compares on every rising irq_req_o.
module tb_irq_pend_ctrl;
    import irq_pkg::*;

`ifdef IRQ_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irq0  = '0;
    logic [7:0] mask0 = '0;
    logic [7:0] irq1  = '0;
    logic [7:0] mask1 = '0;
    logic [7:0] pend0;
    logic [7:0] pend1;

    irq_pend_ctrl_if bus0 ();
    irq_pend_ctrl_if bus1 ();

    irq_pend_ctrl #(.EDGE_MODE(1), .ACK_TIMEOUT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .irq_in(irq0), .irq_mask(mask0),
        .pend_o(pend0), .bus(bus0)
    );

    irq_pend_ctrl #(.EDGE_MODE(1), .ACK_TIMEOUT(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .irq_in(irq1), .irq_mask(mask1),
        .pend_o(pend1), .bus(bus1)
    );

    always #5 clk = ~clk;

    // Reference 8:3 priority encoder, highest index wins.
    function automatic logic [2:0] enc83(input logic [7:0] v);
        enc83 = '0;
        for (int i = 0; i < 8; i++) if (v[i]) enc83 = 3'(i);
    endfunction

    always_comb bus0.enc_code_i = bus0.enc_en_o ? enc83(bus0.enc_i_o) : 3'b000;
    always_comb bus1.enc_code_i = bus1.enc_en_o ? enc83(bus1.enc_i_o) : 3'b000;

    int n_chk = 0;
    int n_err = 0;
    int q0[$];
    int q1[$];
    int cur = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cur++;
    endtask

    task automatic to(input int k);
        while (cur < k) tick();
    endtask

    // Monitor: compares the vector of every new request against the scoreboard.
    logic p0 = 1'b0;
    logic p1 = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (bus0.irq_req_o && !p0) begin
                if (q0.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL dut0 req: got unexpected vec %0d expected none", bus0.irq_vec_o);
                end else chk("dut0 vec", 32'(bus0.irq_vec_o), 32'(q0.pop_front()));
            end
            if (bus1.irq_req_o && !p1) begin
                if (q1.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL dut1 req: got unexpected vec %0d expected none", bus1.irq_vec_o);
                end else chk("dut1 vec", 32'(bus1.irq_vec_o), 32'(q1.pop_front()));
            end
            p0 = bus0.irq_req_o;
            p1 = bus1.irq_req_o;
        end
    end

    initial begin
        int t;
        logic saw;
        bus0.irq_ack_i = 1'b0;
        bus1.irq_ack_i = 1'b0;
        #1;
        chk("reset pend0", 32'(pend0), 32'h00);
        chk("reset req0", 32'(bus0.irq_req_o), 0);
        chk("reset vec0", 32'(bus0.irq_vec_o), 0);
        chk("reset en0", 32'(bus0.enc_en_o), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Single edge-triggered line 5
        t = cur; irq0 = 8'h20; q0.push_back(5);
        to(t + 1 + L); chk("t1 pend set", 32'(pend0), 32'h20);
        to(t + 2 + L); chk("t1 arb en", 32'(bus0.enc_en_o), 1);
                       chk("t1 req early", 32'(bus0.irq_req_o), 0);
        to(t + 3 + L); chk("t1 req", 32'(bus0.irq_req_o), 1);
        to(t + 5 + L); chk("t1 req held", 32'(bus0.irq_req_o), 1);
        bus0.irq_ack_i = 1'b1;
        to(t + 6 + L); bus0.irq_ack_i = 1'b0;
        chk("t1 pend clr", 32'(pend0), 32'h00);
        chk("t1 req drop", 32'(bus0.irq_req_o), 0);
        irq0 = 8'h00;

        // Priority: lines 3 and 1 together
        tick(); t = cur; irq0 = 8'h0A; q0.push_back(3); q0.push_back(1);
        to(t + 1 + L); chk("t2 pend", 32'(pend0), 32'h0A);
        to(t + 3 + L); chk("t2 req a", 32'(bus0.irq_req_o), 1);
        bus0.irq_ack_i = 1'b1;
        to(t + 4 + L); bus0.irq_ack_i = 1'b0;
        chk("t2 pend after a", 32'(pend0), 32'h02);
        to(t + 5 + L); chk("t2 gap", 32'(bus0.irq_req_o), 0);
        to(t + 6 + L); chk("t2 req b", 32'(bus0.irq_req_o), 1);
        bus0.irq_ack_i = 1'b1;
        to(t + 7 + L); bus0.irq_ack_i = 1'b0;
        chk("t2 pend after b", 32'(pend0), 32'h00);
        irq0 = 8'h00;

        // Line 0, then nothing pending
        tick(); t = cur; irq0 = 8'h01; q0.push_back(0);
        to(t + 3 + L); chk("t3 req line0", 32'(bus0.irq_req_o), 1);
        bus0.irq_ack_i = 1'b1;
        to(t + 4 + L); bus0.irq_ack_i = 1'b0;
        chk("t3 pend clr", 32'(pend0), 32'h00);
        irq0 = 8'h00;
        saw = 1'b0;
        repeat (10) begin tick(); saw |= bus0.irq_req_o; end
        chk("t3 no req idle", 32'(saw), 0);

        // Mask line 7, then release it
        t = cur; mask0 = 8'h80; irq0 = 8'h81; q0.push_back(0);
        to(t + 1 + L); chk("t4 pend", 32'(pend0), 32'h81);
                       chk("t4 enc_i", 32'(bus0.enc_i_o), 32'h01);
        to(t + 3 + L); chk("t4 req", 32'(bus0.irq_req_o), 1);
        bus0.irq_ack_i = 1'b1;
        to(t + 4 + L); bus0.irq_ack_i = 1'b0;
        chk("t4 masked stays", 32'(pend0), 32'h80);
        to(t + 8 + L); chk("t4 masked no req", 32'(bus0.irq_req_o), 0);
        chk("t4 pend held", 32'(pend0), 32'h80);
        mask0 = 8'h00; q0.push_back(7);
        to(t + 10 + L); chk("t4 req line7", 32'(bus0.irq_req_o), 1);
        bus0.irq_ack_i = 1'b1;
        to(t + 11 + L); bus0.irq_ack_i = 1'b0;
        chk("t4 pend clr", 32'(pend0), 32'h00);
        irq0 = 8'h00;

        // Timeout of 4 on dut1, then set and ack-clear of the same bit together
        tick(); t = cur; irq1 = 8'h04; q1.push_back(2); q1.push_back(2);
        to(t + 1); irq1 = 8'h00;
        to(t + 3 + L); chk("t5 req", 32'(bus1.irq_req_o), 1);
        to(t + 6 + L); chk("t5 req last", 32'(bus1.irq_req_o), 1);
        to(t + 7 + L); chk("t5 withdrawn", 32'(bus1.irq_req_o), 0);
        chk("t5 pend kept", 32'(pend1), 32'h04);
        to(t + 9); irq1 = 8'h04;
        to(t + 9 + L); chk("t5 re-req", 32'(bus1.irq_req_o), 1);
        bus1.irq_ack_i = 1'b1;
        to(t + 10 + L); bus1.irq_ack_i = 1'b0;
        chk("t5 set wins", 32'(pend1), 32'h04);
        q1.push_back(2);
        to(t + 12 + L); chk("t5 req again", 32'(bus1.irq_req_o), 1);
        bus1.irq_ack_i = 1'b1;
        to(t + 13 + L); bus1.irq_ack_i = 1'b0;
        chk("t5 pend clr", 32'(pend1), 32'h00);
        irq1 = 8'h00;

        // Asynchronous reset during an outstanding request
        tick(); t = cur; irq0 = 8'h10; q0.push_back(4);
        to(t + 3 + L); chk("t6 req", 32'(bus0.irq_req_o), 1);
        #2; rst_n = 1'b0; irq0 = 8'h00;
        #1;
        chk("t6 rst req", 32'(bus0.irq_req_o), 0);
        chk("t6 rst pend", 32'(pend0), 32'h00);
        chk("t6 rst vec", 32'(bus0.irq_vec_o), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (6) tick();
        chk("dut0 queue drained", 32'(q0.size()), 0);
        chk("dut1 queue drained", 32'(q1.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
